ascii_hex_parser: RTL and testbench
===================================

// Module: ascii_hex_parser
//
// PURPOSE
//   Inverse of the nibble-to-ASCII encoder: parses a stream of ASCII hex characters
//   (e.g. bytes from the UART receiver) into binary words for the control path.
//   Digits accumulate MSB-first. A terminator (CR/LF/space) commits the word.
//   Malformed input is flagged and discarded up to the next terminator.
//
// PARAMETERS
//   NIBBLES   4   max hex digits per word; out_word width = 4*NIBBLES
//   DW        $clog2(NIBBLES+1)   width of out_digits (localparam, derived)
//
// PORTS
//   clk         in   1           system clock, all logic on posedge
//   rst         in   1           asynchronous, active-high reset
//   in_valid    in   1           in_char valid
//   in_ready    out  1           parser accepts a char (combinational from state)
//   in_char     in   8           ASCII character
//   out_valid   out  1           out_word/out_digits valid, held until accepted
//   out_ready   in   1           downstream accepts word
//   out_word    out  4*NIBBLES   parsed value, right-aligned, zero-extended
//   out_digits  out  DW          number of digits in out_word (1..NIBBLES)
//   err_char    out  1           1-cycle pulse: invalid character received
//   err_ovf     out  1           1-cycle pulse: more than NIBBLES digits received
//
// BEHAVIOUR
//   - Accept event: in_valid && in_ready.
//   - Char classes:
//       digit      = 0x30-0x39 -> 0-9; 0x41-0x46 -> A-F
//       terminator = 0x0D, 0x0A, 0x20
//       anything else is invalid
//   - States: IDLE (cnt=0), ACC (cnt>0), HOLD (word pending), DROP (discarding).
//   - in_ready = 1 in IDLE/ACC/DROP; 0 in HOLD.
//   - IDLE/ACC, digit accepted:
//       cnt<NIBBLES -> acc <= {acc[4*NIBBLES-5:0], nib}; cnt++; go ACC.
//       cnt==NIBBLES -> err_ovf pulse next cycle; clear acc/cnt; go DROP.
//   - IDLE, terminator: ignored, stay IDLE (blank lines produce no word).
//   - ACC, terminator: out_word<=acc; out_digits<=cnt; out_valid<=1 on the next
//     cycle (1-cycle latency); go HOLD.
//   - IDLE/ACC, invalid char: err_char pulse next cycle; clear acc/cnt; go DROP.
//   - DROP: digits and invalid chars swallowed silently (no further err pulses);
//     terminator -> IDLE.
//   - HOLD: out_word/out_digits stable while out_valid=1 && out_ready=0.
//     On out_valid && out_ready: out_valid<=0; acc/cnt cleared; go IDLE.
//     in_ready is 1 the cycle after the handshake.
//   - Simultaneous events: in_char is never accepted in HOLD (in_ready=0), so a
//     handshake and a char accept cannot coincide.
//   - err_char and err_ovf are mutually exclusive; each is high for exactly one
//     cycle per offending char.
//   - Reset (any time, incl. mid-word or in HOLD): state=IDLE, acc=0, cnt=0,
//     out_valid=0, out_word=0, out_digits=0, err_char=0, err_ovf=0; in_ready=1.
//     A partial word is lost.
//
// CONFIGURATION
//   LOWERCASE_EN defined: 0x61-0x66 ('a'-'f') decode to A-F, same as uppercase.
//   LOWERCASE_EN undefined: 0x61-0x66 are invalid chars -> err_char, DROP.
//
// TESTING
//   1. "1A3F\r", out_ready=1 -> out_word=16'h1A3F, out_digits=4, out_valid one cycle after CR.
//   2. "7\n" -> out_word=16'h0007, out_digits=1; then " \r" -> no out_valid.
//   3. "12345\r" -> err_ovf pulse the cycle after '5', no word;
//      then "00FF\r" -> 16'h00FF, out_digits=4.
//   4. "1G2\r" -> one err_char pulse after 'G', no word, no pulse for '2'; parser back in IDLE.
//   5. "BEEF\r" with out_ready=0 for 10 cycles -> in_ready=0 and out_word=16'hBEEF stable;
//      out_ready=1 -> handshake, in_ready=1 next cycle.
//   6. rst pulse after "AB" -> all outputs 0, in_ready=1; then "C\r" -> 16'h000C.
//      "ff\r" -> 16'h00FF with LOWERCASE_EN; err_char without it.

Source files
------------

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
//   Parses a stream of ASCII hex characters into binary words. Digits accumulate
//   MSB-first; a terminator (CR, LF or space) commits the word. Invalid characters
//   or too many digits raise a one-cycle error pulse. The rest of the word, up to
//   the next terminator, is then discarded.
//
//   Optional feature: define LOWERCASE_EN to accept 'a'-'f' as hex digits.
//   Without it, lowercase letters are invalid characters.
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous active-high reset
//   in_valid   in_char valid
//   in_ready   parser can accept a character (low while a word is pending)
//   in_char    ASCII character
//   out_valid  out_word/out_digits valid, held until out_ready
//   out_ready  downstream accepts the word
//   out_word   parsed value, right-aligned, zero-extended
//   out_digits number of digits in out_word
//   err_char   one-cycle pulse: invalid character received
//   err_ovf    one-cycle pulse: more than NIBBLES digits received
module ascii_hex_parser #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned DW = $clog2(NIBBLES + 1),
  localparam int unsigned WW = 4 * NIBBLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] out_word,
  output logic [DW-1:0] out_digits,
  output logic          err_char,
  output logic          err_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold, StDrop} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] acc_q, acc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic [DW-1:0] digits_q, digits_d;
  logic          out_valid_q, out_valid_d;
  logic          err_char_q, err_char_d;
  logic          err_ovf_q, err_ovf_d;

  logic          is_digit;
  logic          is_term;
  logic [3:0]    nib;
  logic          accept;

  // Character classification. For 'A'-'F' (and 'a'-'f') the low nibble is
  // 1..6, so adding 9 yields 10..15.
  always_comb begin
    is_digit = 1'b0;
    nib      = 4'h0;
    if (in_char >= 8'h30 && in_char <= 8'h39) begin
      is_digit = 1'b1;
      nib      = in_char[3:0];
    end else if (in_char >= 8'h41 && in_char <= 8'h46) begin
      is_digit = 1'b1;
      nib      = in_char[3:0] + 4'd9;
    end
`ifdef LOWERCASE_EN
    else if (in_char >= 8'h61 && in_char <= 8'h66) begin
      is_digit = 1'b1;
      nib      = in_char[3:0] + 4'd9;
    end
`else
    else begin
      is_digit = 1'b0;
    end
`endif
    is_term = (in_char == 8'h0D) || (in_char == 8'h0A) || (in_char == 8'h20);
  end

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    digits_d    = digits_q;
    out_valid_d = out_valid_q;
    err_char_d  = 1'b0;
    err_ovf_d   = 1'b0;

    unique case (state_q)
      StIdle, StAcc: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == DW'(NIBBLES)) begin
              err_ovf_d = 1'b1;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = StDrop;
            end else begin
              acc_d   = {acc_q[WW-5:0], nib};
              cnt_d   = cnt_q + DW'(1);
              state_d = StAcc;
            end
          end else if (is_term) begin
            // A terminator on an empty line produces no word.
            if (state_q == StAcc) begin
              word_d      = acc_q;
              digits_d    = cnt_q;
              out_valid_d = 1'b1;
              state_d     = StHold;
            end
          end else begin
            err_char_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = StDrop;
          end
        end
      end
      StHold: begin
        // out_valid is always set in this state, so out_ready alone completes the handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      StDrop: begin
        if (accept && is_term) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      digits_q    <= '0;
      out_valid_q <= 1'b0;
      err_char_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      digits_q    <= digits_d;
      out_valid_q <= out_valid_d;
      err_char_q  <= err_char_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = word_q;
  assign out_digits = digits_q;
  assign err_char   = err_char_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed testbench for ascii_hex_parser (NIBBLES = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_ascii_hex_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [2:0]  out_digits;
  logic        err_char;
  logic        err_ovf;

  int checks = 0;
  int errors = 0;

  ascii_hex_parser #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_digits(out_digits),
    .err_char  (err_char),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one character for exactly one edge; in_ready must already be high.
  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_word", 32'(out_word), 32'h0);
    chk("rst_errs", {30'd0, err_char, err_ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: "1A3F\r"
    send_str("1A3F");
    chk("t1_no_valid_before_cr", 32'(out_valid), 32'd0);
    send(8'h0D);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", 32'(out_word), 32'h1A3F);
    chk("t1_digits", 32'(out_digits), 32'd4);
    chk("t1_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("t1_valid_cleared", 32'(out_valid), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);

    // 2: "7\n", then blank terminators give no word
    send_str("7");
    send(8'h0A);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_word", 32'(out_word), 32'h0007);
    chk("t2_digits", 32'(out_digits), 32'd1);
    tick();
    send(8'h20);
    chk("t2_space_no_valid", 32'(out_valid), 32'd0);
    send(8'h0D);
    chk("t2_cr_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t2_idle_no_valid", 32'(out_valid), 32'd0);

    // 3: five digits overflow, then a normal word
    send_str("1234");
    chk("t3_no_ovf_at_4", 32'(err_ovf), 32'd0);
    send_str("5");
    chk("t3_ovf_pulse", 32'(err_ovf), 32'd1);
    chk("t3_no_char_err", 32'(err_char), 32'd0);
    send(8'h0D);
    chk("t3_ovf_one_cycle", 32'(err_ovf), 32'd0);
    chk("t3_no_word", 32'(out_valid), 32'd0);
    send_str("00FF");
    send(8'h0D);
    chk("t3_word", 32'(out_word), 32'h00FF);
    chk("t3_digits", 32'(out_digits), 32'd4);
    chk("t3_valid", 32'(out_valid), 32'd1);
    tick();

    // 4: invalid char 'G' mid-word
    send_str("1G");
    chk("t4_char_err", 32'(err_char), 32'd1);
    chk("t4_no_ovf", 32'(err_ovf), 32'd0);
    send_str("2");
    chk("t4_no_second_err", 32'(err_char), 32'd0);
    send(8'h0D);
    chk("t4_no_word", 32'(out_valid), 32'd0);
    send_str("5");
    send(8'h0D);
    chk("t4_idle_word", 32'(out_word), 32'h0005);
    chk("t4_idle_valid", 32'(out_valid), 32'd1);
    tick();

    // Range boundaries: '@' (0x40) and ':' (0x3A) are invalid
    send_str("@");
    chk("bnd_at_err", 32'(err_char), 32'd1);
    send(8'h0D);
    send_str("9:");
    chk("bnd_colon_err", 32'(err_char), 32'd1);
    send(8'h0D);
    chk("bnd_no_word", 32'(out_valid), 32'd0);

    // 5: back-pressure
    out_ready = 1'b0;
    send_str("BEEF");
    send(8'h0D);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_ready", 32'(in_ready), 32'd0);
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_word", 32'(out_word), 32'hBEEF);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t5_after_hs_valid", 32'(out_valid), 32'd0);
    chk("t5_after_hs_ready", 32'(in_ready), 32'd1);

    // 6: reset mid-word
    send_str("AB");
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_word", 32'(out_word), 32'h0);
    chk("t6_rst_digits", 32'(out_digits), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_errs", {30'd0, err_char, err_ovf}, 32'd0);
    tick();
    rst = 1'b0;
    send_str("C");
    send(8'h0D);
    chk("t6_word", 32'(out_word), 32'h000C);
    chk("t6_digits", 32'(out_digits), 32'd1);
    tick();

    // Lowercase
    send_str("f");
`ifdef LOWERCASE_EN
    chk("lc_no_err", 32'(err_char), 32'd0);
    send_str("f");
    send(8'h0D);
    chk("lc_word", 32'(out_word), 32'h00FF);
    chk("lc_valid", 32'(out_valid), 32'd1);
`else
    chk("lc_err", 32'(err_char), 32'd1);
    send_str("f");
    chk("lc_no_second_err", 32'(err_char), 32'd0);
    send(8'h0D);
    chk("lc_no_word", 32'(out_valid), 32'd0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
